// File: rtl/inference_controller_pkg.sv
// Shared types and default sizing for the inference controller.
package inference_controller_pkg;

    localparam int DEF_IMAGE_SIZE     = 256;
    localparam int DEF_NEURON_BITS    = 8;
    localparam int DEF_TIMEOUT_CYCLES = 65535;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        SORT,
        STREAM,
        DRAIN
    } ctrl_state_t;

endpackage

// File: rtl/inference_controller_if.sv
// Host / encoder / core signals seen by the inference controller.
// Suffixes are from the controller's point of view.
interface inference_controller_if #(
    parameter int NEURON_BITS     = inference_controller_pkg::DEF_NEURON_BITS,
    parameter int IMAGE_SIZE_BITS = $clog2(inference_controller_pkg::DEF_IMAGE_SIZE)
);
    logic                   start_i;
    logic                   busy_o;
    logic                   core_clear_o;
    logic                   new_image_o;
    logic                   encoder_rdy_i;
    logic                   aerin_req_i;
    logic                   aerin_ack_i;
    logic                   core_spike_valid_i;
    logic [NEURON_BITS-1:0] core_spike_id_i;
    logic                   first_inference_done_o;
    logic                   result_valid_o;
    logic [NEURON_BITS-1:0] result_id_o;
    logic                   result_timeout_o;
    logic [IMAGE_SIZE_BITS:0] event_count_o;

    // Controller side
    modport slave (
        input  start_i, encoder_rdy_i, aerin_req_i, aerin_ack_i,
               core_spike_valid_i, core_spike_id_i,
        output busy_o, core_clear_o, new_image_o, first_inference_done_o,
               result_valid_o, result_id_o, result_timeout_o, event_count_o
    );

    // Host / environment side
    modport master (
        output start_i, encoder_rdy_i, aerin_req_i, aerin_ack_i,
               core_spike_valid_i, core_spike_id_i,
        input  busy_o, core_clear_o, new_image_o, first_inference_done_o,
               result_valid_o, result_id_o, result_timeout_o, event_count_o
    );
endinterface

// File: rtl/inference_controller_aer_monitor.sv
// Snoops the AER input link: counts accepted events (ACK rising edge while
// REQ is high), saturating at IMAGE_SIZE, and reports when the link is idle.
module aer_event_monitor #(
    parameter int IMAGE_SIZE = 256,
    parameter int CNT_BITS   = $clog2(IMAGE_SIZE) + 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic                en_i,
    input  logic                aerin_req_i,
    input  logic                aerin_ack_i,
    output logic [CNT_BITS-1:0] count_o,
    output logic                link_idle_o
);
    logic                ack_q;
    logic [CNT_BITS-1:0] count_q;
    logic [CNT_BITS-1:0] count_d;
    logic                ack_rise;

    assign ack_rise    = aerin_ack_i & ~ack_q;
    assign link_idle_o = ~aerin_req_i & ~aerin_ack_i;
    assign count_o     = count_q;

    // Next event count: clear wins, otherwise count edges until saturated
    always_comb begin
        // NOTE: assign every always_comb output a default first so no path leaves it unassigned (a latch).
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && aerin_req_i && ack_rise && (count_q != CNT_BITS'(IMAGE_SIZE))) begin
            count_d = count_q + 1'b1;
        end
    end

    // ACK history for edge detection and the event counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values; blocking here would race.
        if (rst_i) begin
            ack_q   <= 1'b0;
            count_q <= '0;
        end else begin
            ack_q   <= aerin_ack_i;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/inference_controller.sv
// Sequences one inference per START: clear core, launch encoder, wait for
// sort, stream until first output spike or timeout, then drain the AER link.
module inference_controller
    import inference_controller_pkg::*;
#(
    parameter int IMAGE_SIZE      = DEF_IMAGE_SIZE,
    parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
    parameter int NEURON_BITS     = DEF_NEURON_BITS,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int TIMEOUT_BITS    = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    inference_controller_if.slave ctl
);
    logic rst_meta_q;
    logic rst_sync_q;

    ctrl_state_t             state_q, state_d;
    logic [TIMEOUT_BITS-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [NEURON_BITS-1:0]  result_id_q, result_id_d;
    logic                    result_timeout_q, result_timeout_d;
    logic                    result_valid_q, result_valid_d;
    logic                    fid_q, fid_d;
    logic                    core_clear;
    logic                    new_image;
    logic                    evt_clr;
    logic                    evt_en;
    logic                    link_idle;
    logic [IMAGE_SIZE_BITS:0] evt_count;

    // Reset takes effect immediately but is released on a clock edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= 1'b1;
        end else begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= rst_meta_q;
        end
    end

    aer_event_monitor #(
        .IMAGE_SIZE (IMAGE_SIZE),
        .CNT_BITS   (IMAGE_SIZE_BITS + 1)
    ) u_aer_mon (
        .clk_i       (clk_i),
        .rst_i       (rst_sync_q),
        .clr_i       (evt_clr),
        .en_i        (evt_en),
        .aerin_req_i (ctl.aerin_req_i),
        .aerin_ack_i (ctl.aerin_ack_i),
        .count_o     (evt_count),
        .link_idle_o (link_idle)
    );

    // Next-state, strobes and result updates; spike takes priority over timeout
    always_comb begin
        state_d          = state_q;
        tmo_cnt_d        = tmo_cnt_q;
        result_id_d      = result_id_q;
        result_timeout_d = result_timeout_q;
        result_valid_d   = 1'b0;
        fid_d            = fid_q;
        core_clear       = 1'b0;
        new_image        = 1'b0;
        evt_clr          = 1'b0;
        evt_en           = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctl.start_i) state_d = CLEAR;
            end
            CLEAR: begin
                core_clear       = 1'b1;
                evt_clr          = 1'b1;
                fid_d            = 1'b0;
                result_id_d      = '0;
                result_timeout_d = 1'b0;
                state_d          = LOAD;
            end
            LOAD: begin
                new_image = 1'b1;
                state_d   = SORT;
            end
            SORT: begin
                if (ctl.encoder_rdy_i) begin
                    tmo_cnt_d = '0;
                    state_d   = STREAM;
                end
            end
            STREAM: begin
                evt_en    = 1'b1;
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (ctl.core_spike_valid_i) begin
                    result_id_d    = ctl.core_spike_id_i;
                    result_valid_d = 1'b1;
                    fid_d          = 1'b1;
                    state_d        = DRAIN;
                end else if (tmo_cnt_q == TIMEOUT_BITS'(TIMEOUT_CYCLES - 1)) begin
                    result_timeout_d = 1'b1;
                    result_valid_d   = 1'b1;
                    fid_d            = 1'b1;
                    state_d          = DRAIN;
                end
            end
            DRAIN: begin
                if (link_idle) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, timeout counter and result registers
    always_ff @(posedge clk_i or posedge rst_sync_q) begin
        if (rst_sync_q) begin
            state_q          <= IDLE;
            tmo_cnt_q        <= '0;
            result_id_q      <= '0;
            result_timeout_q <= 1'b0;
            result_valid_q   <= 1'b0;
            fid_q            <= 1'b0;
        end else begin
            state_q          <= state_d;
            tmo_cnt_q        <= tmo_cnt_d;
            result_id_q      <= result_id_d;
            result_timeout_q <= result_timeout_d;
            result_valid_q   <= result_valid_d;
            fid_q            <= fid_d;
        end
    end

    assign ctl.busy_o                 = (state_q != IDLE);
    assign ctl.core_clear_o           = core_clear;
    assign ctl.new_image_o            = new_image;
    assign ctl.first_inference_done_o = fid_q;
    assign ctl.result_valid_o         = result_valid_q;
    assign ctl.result_id_o            = result_id_q;
    assign ctl.result_timeout_o       = result_timeout_q;
    assign ctl.event_count_o          = evt_count;
endmodule

// File: tb/tb_inference_controller.sv
// Directed self-checking bench for inference_controller.
module tb_inference_controller;
    localparam int TO  = 1000;
    localparam int NB  = 8;
    localparam int IS  = 256;
    localparam int ISB = 8;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    inference_controller_if #(.NEURON_BITS(NB), .IMAGE_SIZE_BITS(ISB)) bus ();

    inference_controller #(
        .IMAGE_SIZE     (IS),
        .NEURON_BITS    (NB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .ctl   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One AER event: REQ and ACK rise together, then both drop
    task automatic handshake();
        bus.aerin_req_i = 1'b1;
        bus.aerin_ack_i = 1'b1;
        tick();
        bus.aerin_req_i = 1'b0;
        bus.aerin_ack_i = 1'b0;
        tick();
    endtask

    // START through CLEAR/LOAD/SORT; returns in the first STREAM cycle
    task automatic start_to_stream(input int sort_wait, input bit spike_in_sort);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        check("clear_pulse", bus.core_clear_o, 1);
        check("clear_busy", bus.busy_o, 1);
        tick();
        check("new_image_pulse", bus.new_image_o, 1);
        check("clear_one_cycle", bus.core_clear_o, 0);
        check("clear_zeroes_fid", bus.first_inference_done_o, 0);
        check("clear_zeroes_id", bus.result_id_o, 0);
        check("clear_zeroes_count", bus.event_count_o, 0);
        tick();
        check("new_image_one_cycle", bus.new_image_o, 0);
        if (spike_in_sort) begin
            bus.core_spike_valid_i = 1'b1;
            bus.core_spike_id_i    = 8'd2;
            tick();
            bus.core_spike_valid_i = 1'b0;
            check("sort_spike_ignored", bus.result_valid_o, 0);
            check("sort_still_busy", bus.busy_o, 1);
        end
        repeat (sort_wait) tick();
        bus.encoder_rdy_i = 1'b1;
        tick();
        bus.encoder_rdy_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, bus.busy_o, 0);
        check({tag, "_core_clear"}, bus.core_clear_o, 0);
        check({tag, "_new_image"}, bus.new_image_o, 0);
        check({tag, "_fid"}, bus.first_inference_done_o, 0);
        check({tag, "_valid"}, bus.result_valid_o, 0);
        check({tag, "_id"}, bus.result_id_o, 0);
        check({tag, "_timeout"}, bus.result_timeout_o, 0);
        check({tag, "_count"}, bus.event_count_o, 0);
    endtask

    initial begin
        int n;
        bus.start_i            = 1'b0;
        bus.encoder_rdy_i      = 1'b0;
        bus.aerin_req_i        = 1'b0;
        bus.aerin_ack_i        = 1'b0;
        bus.core_spike_valid_i = 1'b0;
        bus.core_spike_id_i    = '0;
        rst = 1'b1;
        repeat (3) tick();
        check_all_zero("por");
        rst = 1'b0;
        repeat (3) tick();

        // Reset in the middle of STREAM
        start_to_stream(2, 1'b0);
        repeat (3) handshake();
        check("t1_stream_busy", bus.busy_o, 1);
        check("t1_count3", bus.event_count_o, 3);
        rst = 1'b1;
        tick();
        check_all_zero("t1_rst");
        rst = 1'b0;
        repeat (3) tick();
        check_all_zero("t1_after");

        // Nominal inference: 40 events then neuron 7 fires
        start_to_stream(10, 1'b1);
        repeat (40) handshake();
        check("t2_no_result_yet", bus.result_valid_o, 0);
        bus.core_spike_valid_i = 1'b1;
        bus.core_spike_id_i    = 8'd7;
        tick();
        bus.core_spike_valid_i = 1'b0;
        check("t2_valid", bus.result_valid_o, 1);
        check("t2_id", bus.result_id_o, 7);
        check("t2_count", bus.event_count_o, 40);
        check("t2_fid", bus.first_inference_done_o, 1);
        check("t2_timeout", bus.result_timeout_o, 0);
        tick();
        check("t2_valid_pulse", bus.result_valid_o, 0);
        check("t2_idle", bus.busy_o, 0);
        check("t2_id_held", bus.result_id_o, 7);
        check("t2_fid_held", bus.first_inference_done_o, 1);

        // Saturation: 300 events, START while busy ignored
        start_to_stream(3, 1'b0);
        for (int i = 0; i < 300; i++) begin
            handshake();
            if (i == 150) begin
                bus.start_i = 1'b1;
                tick();
                bus.start_i = 1'b0;
                check("t5_start_ignored", bus.core_clear_o, 0);
                check("t5_still_busy", bus.busy_o, 1);
            end
        end
        check("t5_saturated", bus.event_count_o, 256);
        bus.core_spike_valid_i = 1'b1;
        bus.core_spike_id_i    = 8'd5;
        tick();
        bus.core_spike_valid_i = 1'b0;
        check("t5_valid", bus.result_valid_o, 1);
        check("t5_id", bus.result_id_o, 5);
        check("t5_count", bus.event_count_o, 256);
        tick();

        // Spike on the timeout cycle, later spike ignored, drain holds on REQ
        start_to_stream(1, 1'b0);
        repeat (TO - 1) tick();
        check("t4_no_early_result", bus.result_valid_o, 0);
        bus.core_spike_valid_i = 1'b1;
        bus.core_spike_id_i    = 8'd9;
        bus.aerin_req_i        = 1'b1;
        tick();
        check("t4_valid", bus.result_valid_o, 1);
        check("t4_timeout_lost", bus.result_timeout_o, 0);
        check("t4_id", bus.result_id_o, 9);
        check("t4_fid", bus.first_inference_done_o, 1);
        bus.core_spike_id_i = 8'd3;
        tick();
        bus.core_spike_valid_i = 1'b0;
        check("t4_second_spike_ignored", bus.result_id_o, 9);
        check("t4_valid_pulse", bus.result_valid_o, 0);
        check("t6_drain_busy", bus.busy_o, 1);
        repeat (3) tick();
        check("t6_drain_held", bus.busy_o, 1);
        bus.aerin_req_i = 1'b0;
        tick();
        check("t6_drain_exit", bus.busy_o, 0);
        check("t6_id_held", bus.result_id_o, 9);

        // Timeout with an all-zero image; START also zeroes the old result
        start_to_stream(4, 1'b0);
        n = 0;
        while (!bus.result_valid_o && n < TO + 50) begin
            tick();
            n++;
        end
        check("t3_latency", n, TO);
        check("t3_timeout", bus.result_timeout_o, 1);
        check("t3_fid", bus.first_inference_done_o, 1);
        check("t3_id", bus.result_id_o, 0);
        check("t3_count", bus.event_count_o, 0);
        tick();
        check("t3_valid_pulse", bus.result_valid_o, 0);
        check("t3_idle", bus.busy_o, 0);
        check("t3_timeout_held", bus.result_timeout_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
